// File: rtl/bin_to_bcd_seq.sv
// rtl/bin_to_bcd_seq.sv - sequential double-dabble binary to packed BCD converter
// One fused add-3/shift iteration per cycle; reports overflow and significant digit count.
module bin_to_bcd_seq #(
  parameter int BIN_W  = 32,
  parameter int DIGITS = 10
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [BIN_W-1:0]                  bin,
  output logic                              busy,
  output logic                              done,
  output logic [4*DIGITS-1:0]               bcd,
  output logic                              overflow,
  output logic [$clog2(DIGITS+1)-1:0]       sig_digits
);

  localparam int CNT_W = $clog2(BIN_W+1);
  localparam int SIG_W = $clog2(DIGITS+1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CONV = 2'd1;

  logic [1:0]          state_q, state_d;
  logic [BIN_W-1:0]    op_q, op_d;
  logic [4*DIGITS-1:0] scr_q, scr_d;
  logic                ovs_q, ovs_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [4*DIGITS-1:0] bcd_q, bcd_d;
  logic                ovf_q, ovf_d;
  logic [SIG_W-1:0]    sig_q, sig_d;
  logic                done_q, done_d;

  logic [4*DIGITS-1:0] adj;
  logic [4*DIGITS-1:0] scr_shift;
  logic [BIN_W-1:0]    op_shift;
  logic                ovf_bit;
  logic [SIG_W-1:0]    sig_calc;

  // Per-digit add-3 feeds directly into the shift, so no separate adjust state exists.
  always_comb begin
    adj = '0;
    for (int i = 0; i < DIGITS; i++) begin
      adj[4*i +: 4] = scr_q[4*i +: 4] + ((scr_q[4*i +: 4] >= 4'd5) ? 4'd3 : 4'd0);
    end
    scr_shift = {adj[4*DIGITS-2:0], op_q[BIN_W-1]};
    op_shift  = op_q << 1;
    ovf_bit   = adj[4*DIGITS-1];
  end

  always_comb begin
    sig_calc = SIG_W'(1);
    for (int i = 0; i < DIGITS; i++) begin
      if (scr_shift[4*i +: 4] != 4'd0) sig_calc = SIG_W'(i + 1);
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    scr_d   = scr_q;
    ovs_d   = ovs_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    ovf_d   = ovf_q;
    sig_d   = sig_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d    = bin;
          scr_d   = '0;
          ovs_d   = 1'b0;
          cnt_d   = CNT_W'(BIN_W);
          state_d = S_CONV;
        end
      end
      S_CONV: begin
        op_d  = op_shift;
        scr_d = scr_shift;
        ovs_d = ovs_q | ovf_bit;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          bcd_d   = scr_shift;
          ovf_d   = ovs_q | ovf_bit;
          // A truncated value always occupies every digit, even if its top digits are zero.
          sig_d   = (ovs_q | ovf_bit) ? SIG_W'(DIGITS) : sig_calc;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      scr_q   <= '0;
      ovs_q   <= 1'b0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
      sig_q   <= SIG_W'(1);
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      scr_q   <= scr_d;
      ovs_q   <= ovs_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      ovf_q   <= ovf_d;
      sig_q   <= sig_d;
      done_q  <= done_d;
    end
  end

  assign busy       = (state_q == S_CONV);
  assign done       = done_q;
  assign bcd        = bcd_q;
  assign overflow   = ovf_q;
  assign sig_digits = sig_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb/tb_bin_to_bcd_seq.sv - scoreboard bench for bin_to_bcd_seq
// Three parameterisations share clock and reset; monitors pop expected results on done.
module tb_bin_to_bcd_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        start0 = 1'b0, start1 = 1'b0, start2 = 1'b0;
  logic [31:0] bin0 = '0, bin1 = '0;
  logic [3:0]  bin2 = '0;
  logic        busy0, busy1, busy2, done0, done1, done2;
  logic        ovf0, ovf1, ovf2;
  logic [39:0] bcd0;
  logic [31:0] bcd1;
  logic [7:0]  bcd2;
  logic [3:0]  sig0, sig1;
  logic [1:0]  sig2;

  bin_to_bcd_seq #(.BIN_W(32), .DIGITS(10)) u0 (
    .clk(clk), .rst(rst), .start(start0), .bin(bin0), .busy(busy0), .done(done0),
    .bcd(bcd0), .overflow(ovf0), .sig_digits(sig0));
  bin_to_bcd_seq #(.BIN_W(32), .DIGITS(8)) u1 (
    .clk(clk), .rst(rst), .start(start1), .bin(bin1), .busy(busy1), .done(done1),
    .bcd(bcd1), .overflow(ovf1), .sig_digits(sig1));
  bin_to_bcd_seq #(.BIN_W(4), .DIGITS(2)) u2 (
    .clk(clk), .rst(rst), .start(start2), .bin(bin2), .busy(busy2), .done(done2),
    .bcd(bcd2), .overflow(ovf2), .sig_digits(sig2));

  typedef struct {
    logic [39:0] bcd;
    logic        ovf;
    logic [3:0]  sig;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  int n_pass = 0;
  int n_total = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endfunction

  function automatic logic busy_of(input int id);
    case (id)
      0: return busy0;
      1: return busy1;
      default: return busy2;
    endcase
  endfunction

  function automatic logic done_of(input int id);
    case (id)
      0: return done0;
      1: return done1;
      default: return done2;
    endcase
  endfunction

  always @(negedge clk) begin
    if (done0) begin
      if (q0.size() == 0) begin
        n_total++;
        $display("FAIL u0_unexpected_done: got bcd %0h expected no done", bcd0);
      end else begin
        exp_t e;
        e = q0.pop_front();
        chk("u0_bcd", 64'(bcd0), 64'(e.bcd));
        chk("u0_ovf", 64'(ovf0), 64'(e.ovf));
        chk("u0_sig", 64'(sig0), 64'(e.sig));
      end
    end
  end

  always @(negedge clk) begin
    if (done1) begin
      if (q1.size() == 0) begin
        n_total++;
        $display("FAIL u1_unexpected_done: got bcd %0h expected no done", bcd1);
      end else begin
        exp_t e;
        e = q1.pop_front();
        chk("u1_bcd", 64'(bcd1), 64'(e.bcd));
        chk("u1_ovf", 64'(ovf1), 64'(e.ovf));
        chk("u1_sig", 64'(sig1), 64'(e.sig));
      end
    end
  end

  always @(negedge clk) begin
    if (done2) begin
      if (q2.size() == 0) begin
        n_total++;
        $display("FAIL u2_unexpected_done: got bcd %0h expected no done", bcd2);
      end else begin
        exp_t e;
        e = q2.pop_front();
        chk("u2_bcd", 64'(bcd2), 64'(e.bcd));
        chk("u2_ovf", 64'(ovf2), 64'(e.ovf));
        chk("u2_sig", 64'(sig2), 64'(e.sig));
      end
    end
  end

  task automatic run(input int id, input logic [31:0] val, input logic [39:0] eb,
                     input logic eo, input logic [3:0] es, input int exp_len);
    exp_t e;
    int n = 0;
    e.bcd = eb;
    e.ovf = eo;
    e.sig = es;
    @(posedge clk); #1;
    case (id)
      0: begin q0.push_back(e); bin0 = val; start0 = 1'b1; end
      1: begin q1.push_back(e); bin1 = val; start1 = 1'b1; end
      default: begin q2.push_back(e); bin2 = val[3:0]; start2 = 1'b1; end
    endcase
    @(posedge clk); #1;
    start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
    @(negedge clk);
    while (busy_of(id) && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk($sformatf("busy_len_u%0d_%0h", id, val), 64'(n), 64'(exp_len));
    chk($sformatf("done_pulse_u%0d_%0h", id, val), 64'(done_of(id)), 64'd1);
  endtask

  task automatic wait_idle0();
    int g = 0;
    @(negedge clk);
    while (busy0 && g < 100) begin
      g++;
      @(negedge clk);
    end
    chk("wait_idle0_bound", 64'(busy0), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    exp_t e;
    int cyc, nd, last, bad;

    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(busy0), 64'd0);
    chk("rst_done", 64'(done0), 64'd0);
    chk("rst_bcd", 64'(bcd0), 64'd0);
    chk("rst_ovf", 64'(ovf0), 64'd0);
    chk("rst_sig", 64'(sig0), 64'd1);
    @(posedge clk); #1;
    rst = 1'b0;

    run(0, 32'hFFFF_FFFF, 40'h42_9496_7295, 1'b0, 4'd10, 32);
    run(0, 32'd0,         40'h0,             1'b0, 4'd1,  32);
    run(0, 32'd1000,      40'h10_00,         1'b0, 4'd4,  32);
    run(1, 32'd123456789, 40'h2345_6789,     1'b1, 4'd8,  32);
    run(1, 32'd99999999,  40'h9999_9999,     1'b0, 4'd8,  32);
    run(2, 32'd15,        40'h15,            1'b0, 4'd2,  4);
    run(2, 32'd0,         40'h0,             1'b0, 4'd1,  4);

    repeat (3) @(negedge clk);
    chk("hold_bcd0", 64'(bcd0), 64'h10_00);
    chk("hold_sig0", 64'(sig0), 64'd4);

    // A second start while busy must be dropped; bin wiggling must not leak in.
    e.bcd = 40'h42; e.ovf = 1'b0; e.sig = 4'd2;
    @(posedge clk); #1;
    q0.push_back(e);
    bin0 = 32'd42; start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    start0 = 1'b1; bin0 = 32'd77;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      bin0 = $urandom;
    end
    start0 = 1'b0;
    wait_idle0();
    repeat (40) @(negedge clk);
    chk("ignored_start_idle", 64'(busy0), 64'd0);

    // Start held high: back-to-back conversions every BIN_W+1 cycles.
    e.bcd = 40'h9; e.ovf = 1'b0; e.sig = 4'd1;
    for (int i = 0; i < 3; i++) q0.push_back(e);
    @(posedge clk); #1;
    bin0 = 32'd9; start0 = 1'b1;
    @(posedge clk);
    cyc = 0; nd = 0; last = -1; bad = 0;
    while (nd < 3 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (busy0 === done0) bad++;
      if (done0) begin
        nd++;
        if (last >= 0) chk("held_gap", 64'(cyc - last), 64'd33);
        last = cyc;
        if (nd == 3) start0 = 1'b0;
      end
    end
    chk("held_done_count", 64'(nd), 64'd3);
    chk("held_busy_vs_done", 64'(bad), 64'd0);
    repeat (3) @(negedge clk);
    chk("held_stop", 64'(busy0), 64'd0);

    // Abort with reset during the 10th conversion cycle; no result may appear.
    @(posedge clk); #1;
    bin0 = 32'd555; start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    repeat (10) @(negedge clk);
    chk("abort_was_busy", 64'(busy0), 64'd1);
    rst = 1'b1;
    #1;
    chk("abort_busy", 64'(busy0), 64'd0);
    chk("abort_bcd", 64'(bcd0), 64'd0);
    chk("abort_ovf", 64'(ovf0), 64'd0);
    chk("abort_sig", 64'(sig0), 64'd1);
    chk("abort_done", 64'(done0), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("abort_stays_idle", 64'(busy0), 64'd0);

    run(0, 32'd7, 40'h7, 1'b0, 4'd1, 32);

    repeat (3) @(negedge clk);
    chk("q0_drained", 64'(q0.size()), 64'd0);
    chk("q1_drained", 64'(q1.size()), 64'd0);
    chk("q2_drained", 64'(q2.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
